// File: rtl/aes_block_packer_if.sv
// Word-in / block-out handshake bundle for the AES input packer.
// slave is the packer side, master is the producer/consumer side.
interface aes_block_packer_if #(
  parameter int WORD_W = 32,
  parameter int WORDS  = 4,
  parameter int DEPTH  = 2
);
  localparam int BW = WORD_W * WORDS;
  localparam int NW = $clog2(WORDS + 1);
  localparam int FW = $clog2(DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [BW-1:0]     out_data;
  logic              out_last;
  logic [NW-1:0]     out_nwords;
  logic [FW-1:0]     fill;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_last, out_nwords, fill
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data,
    output out_last, out_nwords, fill
  );
endinterface

// File: rtl/aes_block_packer.sv
// Packs 32-bit words into 128-bit AES blocks (first word in MSBs)
// and queues finished blocks in a small circular FIFO.
module aes_block_packer #(
  parameter int WORD_W = 32,
  parameter int WORDS  = 4,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  aes_block_packer_if.slave bus
);
  localparam int BW = WORD_W * WORDS;
  localparam int IW = $clog2(WORDS);
  localparam int NW = $clog2(WORDS + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);

  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [FW-1:0] FULL     = FW'(DEPTH);

  typedef struct packed {
    logic [BW-1:0] data;
    logic          last;
    logic [NW-1:0] nwords;
  } blk_t;

  blk_t          mem [DEPTH];
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [PW-1:0] hptr;
  logic [PW-1:0] head;
  logic [FW-1:0] fill;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;
  logic [BW-1:0] asm_q;
  logic [BW-1:0] asm_nxt;
  logic [BW-1:0] blk;
  logic          acc;
  logic          pop;
  logic          push;
  logic          done;
  logic          step;

  assign acc  = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;
  assign done = acc && (bus.in_last || idx == LAST_IDX);
  assign step = acc && !done;

  // assembly FSM: idx is the state, a completing word returns to slot 0
  always_ff @(posedge clk) begin
    if (reset) begin
      idx   <= '0;
      asm_q <= '0;
    end else begin
      idx   <= idx_nxt;
      asm_q <= asm_nxt;
    end
  end

  always_comb begin
    idx_nxt = idx;
    unique case (1'b1)
      done:    idx_nxt = '0;
      step:    idx_nxt = idx + IW'(1);
      default: ;
    endcase
  end

  // unused upper slots are still zero because asm_q is cleared per block
  always_comb begin
    blk = asm_q;
    for (int i = 0; i < WORDS; i++) begin
      if (idx == IW'(i)) begin
        blk[BW-1-WORD_W*i -: WORD_W] = bus.in_data;
      end
    end
    push    = done;
    asm_nxt = asm_q;
    unique case (1'b1)
      done:    asm_nxt = '0;
      step:    asm_nxt = blk;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rptr <= '0;
      wptr <= '0;
      hptr <= '0;
      fill <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= '{
          data:   blk,
          last:   bus.in_last,
          nwords: NW'(idx) + NW'(1)
        };
        wptr <= (wptr == LAST_PTR) ? '0 : wptr + PW'(1);
      end
      if (pop) begin
        rptr <= (rptr == LAST_PTR) ? '0 : rptr + PW'(1);
        hptr <= rptr;
      end
      unique case ({push, pop})
        2'b10:   fill <= fill + FW'(1);
        2'b01:   fill <= fill - FW'(1);
        default: ;
      endcase
    end
  end

  // when empty, show the most recently popped entry so outputs hold
  assign head = (fill == '0) ? hptr : rptr;

  assign bus.in_ready  = (fill != FULL);
  assign bus.out_valid = (fill != '0);
  assign bus.fill      = fill;
  assign {bus.out_data, bus.out_last, bus.out_nwords} = mem[head];
endmodule

// File: doc/aes_block_packer.md
# aes_block_packer

Input-side packer for the AES core: accepts the plaintext/ciphertext stream as 32-bit words over a valid/ready handshake, assembles them into 128-bit blocks in FIPS-197 byte order, and buffers completed blocks in a small FIFO. The FIFO head drives the 128-bit load value of the core's state register, with enable = `out_valid && out_ready`. Short final blocks are zero-padded and tagged with their valid-word count.

## Interface
- `WORD_W`, 32, input word width; fixed at 32 for this design.
- `WORDS`, 4, words per block; block width = `WORD_W*WORDS` = 128.
- `DEPTH`, 2, block FIFO entries; legal values ≥ 2.

- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  packer accepts a word this cycle.
- `in_data`  in  32  input word.
- `in_last`  in  1  this word is the final word of the message.
- `out_valid`  out  1  FIFO head block is valid.
- `out_ready`  in  1  consumer takes the head block this cycle.
- `out_data`  out  128  head block; first word of the block is in `[127:96]`.
- `out_last`  out  1  head block ends a message.
- `out_nwords`  out  3  valid words in the head block, 1..4.
- `fill`  out  $clog2(DEPTH+1)  number of blocks in the FIFO.

## Operation
- **Word transfer:** accepted when `in_valid && in_ready`. Block transfer occurs when `out_valid && out_ready`.
- **Assembly:** 128-bit assembly register plus 2-bit word index `idx` (0..3).
  - An accepted word is written into slot `idx`: slot 0 → `[127:96]`, slot 3 → `[31:0]`.
- **FSM states:**
  - FILL: `idx` < 3, no `in_last`. Increment `idx`.
  - COMPLETE: accepted word has `idx`==3 or `in_last`=1.
    - Push block to the FIFO tail with `nwords = idx+1` and `last = in_last`.
    - Slots above `idx` are pushed as zero.
    - Clear the assembly register. Set `idx` to 0.
- **`in_last` on slot 3:** full block, `out_last`=1, `out_nwords`=4.
- **Back-pressure:** `in_ready = (fill != DEPTH)`, derived from registered state only. There is no combinational path from `out_ready` to `in_ready`.
  - `in_ready` is conservative: it drops on a full FIFO even when the current word would not complete a block.
- **FIFO:** circular, with `DEPTH` entries of {data, last, nwords}.
  - Read and write pointers wrap at `DEPTH`.
  - `fill` is incremented on push only, decremented on pop only, and unchanged on simultaneous push and pop.
- **Full FIFO:** no push is possible because `in_ready`=0. A pop frees one entry, and `in_ready` rises the next cycle.
- **Empty FIFO:** `out_valid`=0 and `out_data` is held at its last value. `out_ready` is ignored.
- **Reset:** clears `idx`, the assembly register, the pointers and `fill`.
  - A partially assembled block and all buffered blocks are discarded.
  - Reset has priority over any handshake in the same cycle.

## Timing
- **Output values during and after reset:** `in_ready`=1, `out_valid`=0, `out_data`=0, `out_last`=0, `out_nwords`=0, `fill`=0.
- **Latency:** the word completing a block is accepted on edge N. `out_valid`=1 and the block is visible at the FIFO head after edge N, i.e. in cycle N+1.
- **Throughput:** one word per cycle sustained while `out_ready`=1, giving one block per 4 cycles.
- **Ordering:** blocks leave in push order. `out_data`, `out_last` and `out_nwords` are stable while `out_valid && !out_ready`.
- **`in_ready` is registered:** it reflects `fill` after the previous edge.
- **Producer rule:** `in_data` and `in_last` are don't-care when `in_valid`=0. A producer can hold `in_valid` while `in_ready`=0, and no word is lost.

## Test plan
- **Single block:** reset, then words `0x00112233`, `0x44556677`, `0x8899AABB`, `0xCCDDEEFF` on consecutive cycles with `out_ready`=1.
  - Required: one cycle after the 4th word, `out_data`=`00112233_44556677_8899AABB_CCDDEEFF`, `out_nwords`=4, `out_last`=0.
- **Short final block:** `0xDEADBEEF`, then `0x01020304` with `in_last`=1.
  - Required: `out_data`=`DEADBEEF_01020304_00000000_00000000`, `out_nwords`=2, `out_last`=1, and `idx` returns to 0.
- **Back-pressure:** `out_ready`=0, stream 12 words.
  - Required: after 8 words `fill`=2 and `in_ready`=0, and word 9 is held at the input.
  - Raise `out_ready` for one cycle: `in_ready`=1 the next cycle, and all 3 blocks emerge in order unchanged.
- **Simultaneous push and pop at `fill`=1:** the 4th word is accepted on the same edge as a pop.
  - Required: `fill` stays 1 and `out_data` becomes the new block.
- **Reset mid-block:** after 2 words, assert `reset` for one cycle.
  - Required: all outputs at reset values. The next 4 words form a clean block with no residue from the first 2.
- **Random soak:** randomized `in_valid`/`out_ready` with 1000 words and random `in_last`.
  - Required: the scoreboard matches data, `nwords` and `last` for every block, and no word is lost or duplicated.
